// File: rtl/program_loader.sv
// program_loader: boot-time image loader. Streams 32-bit words from a
// valid/ready source into data memory at consecutive word addresses,
// holds the CPU in reset until the image is complete, and keeps a running
// modulo-2^32 checksum of every accepted word.
module program_loader #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  in_valid,
   input  logic [31:0]           in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [31:0]           checksum
);

   localparam int unsigned         MAX_WORDS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] MAX_CNT   = (ADDR_WIDTH + 1)'(MAX_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t              state;
   logic [ADDR_WIDTH:0] count_q;
   logic [ADDR_WIDTH:0] counter;
   logic                handshake;
   logic [31:0]         word_offset;

   // Transfer qualifier and byte offset of the word about to be written.
   always_comb begin
      handshake   = in_valid & in_ready;
      word_offset = 32'(counter) << 2;
   end

   // Load controller; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         count_q  <= '0;
         counter  <= '0;
         in_ready <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= BASE_ADDR;
         mem_data <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
         checksum <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               mem_we <= 1'b0;
               if (start) begin
                  if (word_count == '0) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else if (word_count > MAX_CNT) begin
                     state <= ST_ERR;
                     error <= 1'b1;
                  end else begin
                     state    <= ST_LOAD;
                     count_q  <= word_count;
                     counter  <= '0;
                     checksum <= '0;
                     in_ready <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               if (handshake) begin
                  mem_we   <= 1'b1;
                  mem_addr <= BASE_ADDR + word_offset;
                  mem_data <= in_data;
                  checksum <= checksum + in_data;
                  counter  <= counter + 1'b1;
                  // Last word: drop in_ready on the same edge so no extra word slips in.
                  if (counter == count_q - 1'b1) begin
                     state    <= ST_DONE;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end
               end else begin
                  mem_we <= 1'b0;
               end
            end

            ST_DONE: begin
               mem_we   <= 1'b0;
               in_ready <= 1'b0;
            end

            ST_ERR: begin
               mem_we   <= 1'b0;
               in_ready <= 1'b0;
               error    <= 1'b1;
               cpu_hold <= 1'b1;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time stage upstream of the multicycle CPU core. It accepts a stream of 32-bit instruction/data words over a valid/ready handshake and writes them into the core's data memory at consecutive word addresses. While loading, it holds the CPU control FSM and PC in reset via cpu_hold. It releases the core only after the full image is written, and reports a running 32-bit checksum.

Parameters:
ADDR_WIDTH, 10, word-address width of the loadable region (MAX_WORDS = 2**ADDR_WIDTH)
BASE_ADDR, 32'h0000_0000, byte address of the first word written (word aligned)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin load; sampled only in IDLE
word_count  input  ADDR_WIDTH+1  number of words to load; latched on start
in_valid  input  1  upstream word valid
in_data  input  32  upstream word
in_ready  output  1  loader can accept a word this cycle
mem_we  output  1  data memory write enable, one-cycle pulse per word
mem_addr  output  32  data memory byte address
mem_data  output  32  data memory write data
cpu_hold  output  1  high = CPU FSM/PC held; low = CPU runs
done  output  1  image fully loaded
error  output  1  illegal word_count
checksum  output  32  modulo-2^32 sum of accepted words

Behaviour:
- One clock (clk). Reset is synchronous and active-low: rst_n is sampled on the rising clk edge only. All outputs are registered.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_data=0, cpu_hold=1, done=0, error=0, checksum=0, internal counter=0.
- States: IDLE, LOAD, DONE, ERR.
- IDLE: start=1 evaluates word_count:
  - 0 -> DONE.
  - 1..MAX_WORDS -> LOAD; latch count; counter=0; checksum=0.
  - >MAX_WORDS -> ERR.
  - start=0 -> stay in IDLE.
- LOAD:
  - in_ready=1 for the whole state.
  - A handshake is in_valid&in_ready at a rising edge. On each handshake, at the same edge:
    - mem_we<=1
    - mem_addr<=BASE_ADDR+(counter<<2)
    - mem_data<=in_data
    - checksum<=checksum+in_data (wraps mod 2^32)
    - counter<=counter+1
  - Latency: word accepted at edge N is written to memory during cycle N+1, with mem_we high for exactly one cycle. Back-to-back handshakes give back-to-back mem_we pulses.
  - No handshake: mem_we<=0. mem_addr and mem_data hold.
  - Handshake with counter==count-1 -> DONE. in_ready falls at that same edge, so no extra word is accepted.
- DONE:
  - cpu_hold=0, done=1, in_ready=0.
  - mem_we=0 after the final write pulse.
  - start is ignored. Only reset exits.
- ERR:
  - error=1, cpu_hold=1, in_ready=0, mem_we=0.
  - start is ignored. Only reset exits.
- in_valid while in_ready=0 is ignored. Upstream must hold in_data stable until the handshake.
- start and in_valid asserted in the same cycle in IDLE: start is taken, and no word is accepted that cycle (in_ready is still 0).
- Reset mid-LOAD: return to IDLE with all reset values. Memory already written is left as is. Counter and checksum are cleared. The next start reloads from BASE_ADDR.
- cpu_hold changes only on IDLE/LOAD->DONE (falls) and on reset (rises).

Test Plan:
- Reset: hold rst_n=0 for 2 edges -> in_ready=0, mem_we=0, cpu_hold=1, done=0, error=0, checksum=0, mem_addr=0.
- Load 3 words, in_valid continuous: word_count=3, data 0x20080005, 0x20090007, 0x01095020 -> mem_we pulses in 3 consecutive cycles at mem_addr 0x0, 0x4, 0x8 with matching mem_data; checksum=0x411A502C; done=1 and cpu_hold=0 in the cycle after the last handshake.
- Bubbles: word_count=2, in_valid pattern 1,0,0,1 -> exactly two mem_we pulses at 0x0 and 0x4, each one cycle after its handshake; in_ready=0 after the second handshake.
- Boundaries, one run each:
  - word_count=0 -> DONE next cycle, no mem_we.
  - word_count=1025 (ADDR_WIDTH=10) -> error=1, cpu_hold=1, in_ready stays 0.
  - word_count=1024 -> 1024 writes, last at 0xFFC.
- Checksum wrap: word_count=2, data 0xFFFFFFFF then 0x00000002 -> checksum=0x00000001.
- Reset mid-load: word_count=4, assert rst_n=0 after 2 handshakes -> IDLE, checksum=0, cpu_hold=1. A new start with word_count=1 and data 0xDEADBEEF -> single write at 0x0, checksum=0xDEADBEEF, done=1.
